// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - state encoding, segment codes and counter-width helper for the gate controller
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_PASS  = 3'd1,
        ST_WRONG_PASS = 3'd2,
        ST_RIGHT_PASS = 3'd3,
        ST_STOP       = 3'd4,
        ST_LOCKED     = 3'd5
    } state_t;

    // Active-low segments, bit order gfedcba
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_G     = 7'b1000010;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Bits needed to hold values 0..max_val, never less than one
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/parking_occupancy.sv
// rtl/parking_occupancy.sv - exit edge detect and saturating up/down occupancy counter
module parking_occupancy
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    localparam int OCC_W    = cnt_w(NUM_SLOTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exit_sensor,
    input  logic             entry_inc,
    output logic [OCC_W-1:0] free_slots,
    output logic             full
);

    localparam logic [OCC_W-1:0] CAP = OCC_W'(NUM_SLOTS);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             exit_q, exit_d;
    logic             exit_dec;

    always_comb begin
        exit_d   = exit_sensor;
        exit_dec = exit_sensor && !exit_q && (occ_q != '0);
        occ_d    = occ_q;
        // An entry and an exit on the same edge cancel out
        if (entry_inc && !exit_dec) begin
            if (occ_q != CAP) begin
                occ_d = occ_q + 1'b1;
            end
        end else if (exit_dec && !entry_inc) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= '0;
            exit_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            exit_q <= exit_d;
        end
    end

    assign free_slots = CAP - occ_q;
    assign full       = (occ_q == CAP);

endmodule

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - parking gate FSM with password check, lockout, timeout and LED/HEX decode
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int                PASS_W         = 2,
    parameter logic [PASS_W-1:0] PASS_1_KEY     = PASS_W'(1),
    parameter logic [PASS_W-1:0] PASS_2_KEY     = PASS_W'(2),
    parameter int                NUM_SLOTS      = 4,
    parameter int                MAX_TRIES      = 3,
    parameter int                TIMEOUT_CYCLES = 50,
    parameter int                LOCK_CYCLES    = 16,
    parameter int                BLINK_DIV      = 4,
    localparam int               OCC_W          = cnt_w(NUM_SLOTS)
) (
    input  logic              clock_in,
    input  logic              rst_in,
    input  logic              Front_Sensor,
    input  logic              Back_Sensor,
    input  logic              Exit_Sensor,
    input  logic [PASS_W-1:0] pass_1,
    input  logic [PASS_W-1:0] pass_2,
    input  logic              pass_valid,
    output logic              G_LED,
    output logic              R_LED,
    output logic [6:0]        HEX_1,
    output logic [6:0]        HEX_2,
    output logic [OCC_W-1:0]  free_slots,
    output logic              full,
    output logic              locked
);

    localparam int TRY_W = cnt_w(MAX_TRIES);
    localparam int TMR_W = cnt_w((TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES);
    localparam int BLK_W = cnt_w(2 * BLINK_DIV - 1);

    localparam logic [TRY_W-1:0] MAX_T     = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(2 * BLINK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_ON    = BLK_W'(BLINK_DIV);

    state_t           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [BLK_W-1:0] blink_q, blink_d;
    logic             match;
    logic             entry_inc;
    logic             blink_on;

    parking_occupancy #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_occupancy (
        .clk         (clock_in),
        .rst_n       (rst_in),
        .exit_sensor (Exit_Sensor),
        .entry_inc   (entry_inc),
        .free_slots  (free_slots),
        .full        (full)
    );

    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        timer_d   = timer_q;
        entry_inc = 1'b0;
        match     = pass_valid && (pass_1 == PASS_1_KEY) && (pass_2 == PASS_2_KEY);
        tries_inc = tries_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (Front_Sensor && !full) begin
                    state_d = ST_WAIT_PASS;
                end
            end
            ST_WAIT_PASS, ST_WRONG_PASS: begin
                // The timer doubles as the no-keypad-activity counter here
                if (pass_valid) begin
                    timer_d = '0;
                    if (match) begin
                        state_d = ST_RIGHT_PASS;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_inc;
                        state_d = (tries_inc == MAX_T) ? ST_LOCKED : ST_WRONG_PASS;
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    tries_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RIGHT_PASS: begin
                if (Back_Sensor) begin
                    entry_inc = 1'b1;
                    state_d   = Front_Sensor ? ST_STOP : ST_IDLE;
                end
            end
            ST_STOP: begin
                if (pass_valid) begin
                    if (match) begin
                        tries_d = '0;
                        state_d = full ? ST_IDLE : ST_RIGHT_PASS;
                    end else begin
                        tries_d = tries_inc;
                        if (tries_inc == MAX_T) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = ST_IDLE;
                    tries_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state change restarts both the dwell timer and the blink phase
        if (state_d != state_q) begin
            timer_d = '0;
            blink_d = '0;
        end else begin
            blink_d = (blink_q == BLK_LAST) ? '0 : blink_q + 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            tries_q <= '0;
            timer_q <= '0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
        end
    end

    assign blink_on = (blink_q < BLK_ON);
    assign locked   = (state_q == ST_LOCKED);

    always_comb begin
        G_LED = 1'b0;
        R_LED = 1'b0;
        HEX_1 = SEG_BLANK;
        HEX_2 = SEG_BLANK;
        case (state_q)
            ST_IDLE: begin
                if (full) begin
                    R_LED = 1'b1;
                    HEX_1 = SEG_F;
                    HEX_2 = SEG_L;
                end
            end
            ST_WAIT_PASS: begin
                R_LED = 1'b1;
                HEX_1 = SEG_E;
                HEX_2 = SEG_N;
            end
            ST_WRONG_PASS: begin
                R_LED = blink_on;
                HEX_1 = SEG_E;
                HEX_2 = SEG_E;
            end
            ST_RIGHT_PASS: begin
                G_LED = blink_on;
                HEX_1 = SEG_G;
                HEX_2 = SEG_O;
            end
            ST_STOP: begin
                R_LED = blink_on;
                HEX_1 = SEG_S;
                HEX_2 = SEG_P;
            end
            ST_LOCKED: begin
                R_LED = 1'b1;
                HEX_1 = SEG_L;
                HEX_2 = SEG_C;
            end
            default: begin
                G_LED = 1'b0;
            end
        endcase
    end

endmodule
